// File: rtl/saturate_clamp_if.sv
// Bus bundle for saturate_clamp: sample input, clamped outputs and the saturation counter.
interface saturate_clamp_if #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
);
  logic [IN_W-1:0]  din;
  logic             in_valid;
  logic             count_clr;
  logic [OUT_W-1:0] dout_c;
  logic             sat_c;
  logic [OUT_W-1:0] dout;
  logic             out_valid;
  logic             sat_flag;
  logic [CNT_W-1:0] sat_count;

  modport master (
    output din, in_valid, count_clr,
    input  dout_c, sat_c, dout, out_valid, sat_flag, sat_count
  );

  modport slave (
    input  din, in_valid, count_clr,
    output dout_c, sat_c, dout, out_valid, sat_flag, sat_count
  );
endinterface

// File: rtl/saturate_clamp.sv
// Width-reducing clamp: combinational saturated value plus a registered copy with
// valid, overflow flag and a sticky-at-max saturation event counter.
module saturate_clamp #(
  parameter int IN_W        = 10,
  parameter int OUT_W       = 8,
  parameter int SIGNED_MODE = 0,
  parameter int CNT_W       = 16
) (
  input logic            clk,
  input logic            rst,
  saturate_clamp_if.slave bus
);
  logic [OUT_W-1:0] limit_c;
  logic [OUT_W-1:0] clamp_c;
  logic             over_c;

  // Limit code: all ones when unsigned; sign bit then its complement when signed.
  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_limit
    if (SIGNED_MODE != 0 && gi == OUT_W - 1) begin : g_msb
      assign limit_c[gi] = bus.din[IN_W-1];
    end else if (SIGNED_MODE != 0) begin : g_mag
      assign limit_c[gi] = ~bus.din[IN_W-1];
    end else begin : g_ones
      assign limit_c[gi] = 1'b1;
    end
  end

  if (SIGNED_MODE != 0) begin : g_signed
    logic [IN_W-OUT_W:0] top_bits;
    assign top_bits = bus.din[IN_W-1:OUT_W-1];
    assign over_c   = ~((&top_bits) | ~(|top_bits));
  end else begin : g_unsigned
    assign over_c = |bus.din[IN_W-1:OUT_W];
  end

  assign clamp_c    = over_c ? limit_c : bus.din[OUT_W-1:0];
  assign bus.dout_c = clamp_c;
  assign bus.sat_c  = over_c;

  logic [OUT_W-1:0] dout_q, dout_d;
  logic             out_valid_q, out_valid_d;
  logic             sat_flag_q, sat_flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    dout_d      = dout_q;
    out_valid_d = bus.in_valid;
    sat_flag_d  = over_c & bus.in_valid;
    cnt_d       = cnt_q;
    if (bus.in_valid) begin
      dout_d = clamp_c;
    end
    // Clear wins over a same-cycle increment; the counter parks at all ones.
    if (bus.count_clr) begin
      cnt_d = '0;
    end else if (bus.in_valid && over_c && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      sat_flag_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      sat_flag_q  <= sat_flag_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sat_flag  = sat_flag_q;
  assign bus.sat_count = cnt_q;
endmodule

// File: tb/tb_saturate_clamp.sv
// Bench for saturate_clamp: an unsigned (4-bit counter) and a signed instance fed the same stream.
module tb_saturate_clamp;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] din = '0;
  logic       in_valid = 1'b0;
  logic       count_clr = 1'b0;

  always #5 clk = ~clk;

  saturate_clamp_if #(.IN_W(10), .OUT_W(8), .CNT_W(4))  if_a ();
  saturate_clamp_if #(.IN_W(10), .OUT_W(8), .CNT_W(16)) if_b ();

  assign if_a.din = din;  assign if_a.in_valid = in_valid;  assign if_a.count_clr = count_clr;
  assign if_b.din = din;  assign if_b.in_valid = in_valid;  assign if_b.count_clr = count_clr;

  saturate_clamp #(.IN_W(10), .OUT_W(8), .SIGNED_MODE(0), .CNT_W(4)) u_uns (
    .clk(clk), .rst(rst), .bus(if_a)
  );
  saturate_clamp #(.IN_W(10), .OUT_W(8), .SIGNED_MODE(1), .CNT_W(16)) u_sgn (
    .clk(clk), .rst(rst), .bus(if_b)
  );

  typedef struct {
    logic [9:0] din;
    logic [7:0] u_dout;
    logic       u_sat;
    logic [7:0] s_dout;
    logic       s_sat;
  } vec_t;

  typedef struct {
    logic [7:0] u_dout;
    logic       u_sat;
    logic [7:0] s_dout;
    logic       s_sat;
  } exp_t;

  vec_t       tbl [12];
  exp_t       sb_q [$];
  exp_t       mon_e;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       exp_ov = 1'b0;
  logic [7:0] hold_u = '0;
  logic [7:0] hold_s = '0;
  int         cnt_u = 0;
  int         cnt_s = 0;
  bit         mon_on = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] mdl_u(input logic [9:0] d);
    if (d > 10'd255) return {1'b1, 8'hFF};
    return {1'b0, d[7:0]};
  endfunction

  function automatic logic [8:0] mdl_s(input logic [9:0] d);
    int sd;
    sd = int'($signed(d));
    if (sd > 127)  return {1'b1, 8'h7F};
    if (sd < -128) return {1'b1, 8'h80};
    return {1'b0, d[7:0]};
  endfunction

  // Drive one cycle at the falling edge, check the combinational outputs, update the model.
  task automatic step(input logic [9:0] d, input logic v, input logic clr, input logic r,
                      input logic [7:0] eu, input logic esu, input logic [7:0] es, input logic ess);
    exp_t e;
    @(negedge clk);
    din = d; in_valid = v; count_clr = clr; rst = r;
    #1;
    chk("dout_c_uns", if_a.dout_c, eu);
    chk("sat_c_uns",  if_a.sat_c,  esu);
    chk("dout_c_sgn", if_b.dout_c, es);
    chk("sat_c_sgn",  if_b.sat_c,  ess);
    if (r) begin
      exp_ov = 1'b0; cnt_u = 0; cnt_s = 0; hold_u = '0; hold_s = '0;
    end else begin
      exp_ov = v;
      if (v) begin
        e.u_dout = eu; e.u_sat = esu; e.s_dout = es; e.s_sat = ess;
        sb_q.push_back(e);
      end
      if (clr) begin
        cnt_u = 0; cnt_s = 0;
      end else if (v) begin
        if (esu && cnt_u < 15)    cnt_u++;
        if (ess && cnt_s < 65535) cnt_s++;
      end
    end
  endtask

  task automatic step_m(input logic [9:0] d, input logic v, input logic clr, input logic r);
    logic [8:0] mu, ms;
    mu = mdl_u(d);
    ms = mdl_s(d);
    step(d, v, clr, r, mu[7:0], mu[8], ms[7:0], ms[8]);
  endtask

  // Registered-path monitor, sampled 2 time units after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (mon_on) begin
        chk("out_valid_uns", if_a.out_valid, exp_ov);
        chk("out_valid_sgn", if_b.out_valid, exp_ov);
        chk("sat_count_uns", if_a.sat_count, cnt_u);
        chk("sat_count_sgn", if_b.sat_count, cnt_s);
        if (if_a.out_valid === 1'b1) begin
          if (sb_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_empty: got out_valid 1 expected no pending sample at %0t", $time);
          end else begin
            mon_e = sb_q.pop_front();
            chk("dout_uns",     if_a.dout,     mon_e.u_dout);
            chk("sat_flag_uns", if_a.sat_flag, mon_e.u_sat);
            chk("dout_sgn",     if_b.dout,     mon_e.s_dout);
            chk("sat_flag_sgn", if_b.sat_flag, mon_e.s_sat);
            hold_u = mon_e.u_dout;
            hold_s = mon_e.s_dout;
            $display("tx t=%0t uns dout=%0d sat=%0b cnt=%0d | sgn dout=0x%02h sat=%0b cnt=%0d",
                     $time, if_a.dout, if_a.sat_flag, if_a.sat_count,
                     if_b.dout, if_b.sat_flag, if_b.sat_count);
          end
        end else begin
          chk("dout_hold_uns", if_a.dout, hold_u);
          chk("dout_hold_sgn", if_b.dout, hold_s);
          chk("sat_flag_idle_uns", if_a.sat_flag, 1'b0);
          chk("sat_flag_idle_sgn", if_b.sat_flag, 1'b0);
        end
      end
    end
  end

  initial begin
    logic [9:0] rd;
    logic       rv, rc;
    //           din      uns dout  sat   sgn dout sat
    tbl[0]  = '{10'd200,  8'd200,  1'b0, 8'h7F, 1'b1};
    tbl[1]  = '{10'd255,  8'd255,  1'b0, 8'h7F, 1'b1};
    tbl[2]  = '{10'd256,  8'd255,  1'b1, 8'h7F, 1'b1};
    tbl[3]  = '{10'd248,  8'd248,  1'b0, 8'h7F, 1'b1};
    tbl[4]  = '{10'd1016, 8'd255,  1'b1, 8'hF8, 1'b0};
    tbl[5]  = '{10'h07F,  8'h7F,   1'b0, 8'h7F, 1'b0};
    tbl[6]  = '{10'h080,  8'h80,   1'b0, 8'h7F, 1'b1};
    tbl[7]  = '{10'h200,  8'hFF,   1'b1, 8'h80, 1'b1};
    tbl[8]  = '{10'h3FF,  8'hFF,   1'b1, 8'hFF, 1'b0};
    tbl[9]  = '{10'h000,  8'h00,   1'b0, 8'h00, 1'b0};
    tbl[10] = '{10'h380,  8'hFF,   1'b1, 8'h80, 1'b0};
    tbl[11] = '{10'h37F,  8'hFF,   1'b1, 8'h80, 1'b1};

    step_m(10'd0, 1'b0, 1'b0, 1'b1);
    step_m(10'd0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 12; i++)
      step(tbl[i].din, 1'b1, 1'b0, 1'b0, tbl[i].u_dout, tbl[i].u_sat, tbl[i].s_dout, tbl[i].s_sat);

    // Clear beats a coincident saturating sample, then the 4-bit counter must stick at 15.
    step_m(10'h300, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step_m(10'h300, 1'b1, 1'b0, 1'b0);
    step_m(10'h3FF, 1'b0, 1'b0, 1'b0);
    step_m(10'h3FF, 1'b0, 1'b0, 1'b0);
    step_m(10'h300, 1'b1, 1'b1, 1'b0);
    step_m(10'h2AA, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a stream drops the sample presented with it.
    step_m(10'd17,  1'b1, 1'b0, 1'b0);
    step_m(10'd300, 1'b1, 1'b0, 1'b0);
    step_m(10'd42,  1'b1, 1'b0, 1'b1);
    step_m(10'd99,  1'b0, 1'b0, 1'b0);
    step_m(10'd77,  1'b1, 1'b0, 1'b0);
    step_m(10'd600, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rd = 10'($urandom_range(0, 1023));
      rv = ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 15) == 0);
      step_m(rd, rv, rc, 1'b0);
    end

    step_m(10'd0, 1'b0, 1'b0, 1'b0);
    step_m(10'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    mon_on = 1'b0;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
